// File: rtl/bcd_countdown.sv
// bcd_countdown: loadable multi-digit BCD down-counter with borrow chain and done pulse.
// Optional: define BCD_COUNTDOWN_AUTO_RELOAD_EN to reload the last loaded value at terminal count.
module bcd_countdown #(
   parameter int DIGITS = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   load_val,
   input  logic                  start,
   input  logic                  pause,
   input  logic                  tick,
   output logic [4*DIGITS-1:0]   q,
   output logic [DIGITS-2:0]     borrow,
   output logic                  busy,
   output logic                  done,
   output logic                  load_err
);

   localparam int W = 4 * DIGITS;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      PAUSED = 2'd2
   } state_t;

   state_t state;
   state_t state_n;

   logic [W-1:0]      q_dec;
   logic [W-1:0]      q_next;
   logic [DIGITS-1:0] low_zero;
   logic              load_ok;
   logic              q_zero;
   logic              at_one;
   logic              pause_act;
   logic              start_act;
   logic              dec;
   logic              term;

`ifdef BCD_COUNTDOWN_AUTO_RELOAD_EN
   logic [W-1:0]      reload;
   logic              reload_hit;
`endif

   // Digit validity of the load value and the per-digit decremented count
   always_comb begin
      load_ok     = 1'b1;
      low_zero    = '0;
      low_zero[0] = 1'b1;
      q_dec       = q;
      for (int i = 0; i < DIGITS; i++) begin
         if (load_val[4*i +: 4] > 4'd9)
            load_ok = 1'b0;
      end
      for (int i = 1; i < DIGITS; i++) begin
         low_zero[i] = low_zero[i-1] & (q[4*i-4 +: 4] == 4'd0);
      end
      for (int i = 0; i < DIGITS; i++) begin
         if (low_zero[i]) begin
            if (q[4*i +: 4] == 4'd0)
               q_dec[4*i +: 4] = 4'd9;
            else
               q_dec[4*i +: 4] = q[4*i +: 4] - 4'd1;
         end
      end
   end

   // Command arbitration: load beats pause beats start beats tick
   always_comb begin
      q_zero    = (q == '0);
      at_one    = (q == W'(1));
      pause_act = ~load & pause & (state == RUN);
      start_act = ~load & ~pause & start &
                  (((state == IDLE) & ~q_zero) | (state == PAUSED));
      dec       = (state == RUN) & tick & ~load & ~pause & ~start_act;
      term      = dec & at_one;
   end

`ifdef BCD_COUNTDOWN_AUTO_RELOAD_EN
   // A zero reload value means no periodic restart
   always_comb begin
      reload_hit = term & (reload != '0);
   end
`endif

   // Borrow into digit i fires exactly when digit i decrements
   always_comb begin
      borrow = '0;
      for (int i = 1; i < DIGITS; i++) begin
         borrow[i-1] = dec & low_zero[i];
      end
   end

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         state <= IDLE;
      else
         state <= state_n;
   end

   // Next-state logic
   always_comb begin
      state_n = state;
      if (load) begin
         if (load_ok)
            state_n = IDLE;
      end else if (pause_act) begin
         state_n = PAUSED;
      end else if (start_act) begin
         state_n = RUN;
`ifdef BCD_COUNTDOWN_AUTO_RELOAD_EN
      end else if (term & ~reload_hit) begin
`else
      end else if (term) begin
`endif
         state_n = IDLE;
      end
   end

   // State-derived outputs
   always_comb begin
      busy = (state != IDLE);
   end

   // Next count value
   always_comb begin
      q_next = q;
      if (load & load_ok)
         q_next = load_val;
`ifdef BCD_COUNTDOWN_AUTO_RELOAD_EN
      else if (reload_hit)
         q_next = reload;
`endif
      else if (dec)
         q_next = q_dec;
   end

   // Count register and registered status pulses
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         q        <= '0;
         done     <= 1'b0;
         load_err <= 1'b0;
      end else begin
         q        <= q_next;
         done     <= term;
         load_err <= load & ~load_ok;
      end
   end

`ifdef BCD_COUNTDOWN_AUTO_RELOAD_EN
   // Reload register tracks the last accepted load
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         reload <= '0;
      else if (load & load_ok)
         reload <= load_val;
   end
`endif

endmodule

// File: tb/tb_bcd_countdown.sv
// tb_bcd_countdown: directed stimulus with a decimal-value reference model.
// Honours BCD_COUNTDOWN_AUTO_RELOAD_EN when defined.
module tb_bcd_countdown;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        load = 1'b0;
   logic [15:0] load_val = 16'h0;
   logic        start = 1'b0;
   logic        pause = 1'b0;
   logic        tick = 1'b0;
   logic [15:0] q;
   logic [2:0]  borrow;
   logic        busy;
   logic        done;
   logic        load_err;

   int total = 0;
   int bad = 0;
   logic [2:0] bpre = 3'b0;

   int m_val = 0;
   int m_st = 0;
   int m_reload = 0;
   bit m_done = 1'b0;
   bit m_err = 1'b0;

   bcd_countdown #(.DIGITS(4)) dut (
      .clk(clk),
      .reset(reset),
      .load(load),
      .load_val(load_val),
      .start(start),
      .pause(pause),
      .tick(tick),
      .q(q),
      .borrow(borrow),
      .busy(busy),
      .done(done),
      .load_err(load_err)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] to_bcd(input int v);
      logic [15:0] r;
      int t;
      t = v;
      r = 16'h0;
      for (int i = 0; i < 4; i++) begin
         r[4*i +: 4] = 4'(t % 10);
         t = t / 10;
      end
      return r;
   endfunction

   function automatic bit bcd_ok(input logic [15:0] b);
      bit ok;
      ok = 1'b1;
      for (int i = 0; i < 4; i++)
         if (b[4*i +: 4] > 4'd9) ok = 1'b0;
      return ok;
   endfunction

   function automatic int bcd_int(input logic [15:0] b);
      int r;
      r = 0;
      for (int i = 3; i >= 0; i--)
         r = r * 10 + int'(b[4*i +: 4]);
      return r;
   endfunction

   function automatic logic [2:0] exp_borrow();
      logic [2:0] r;
      int p;
      r = 3'b0;
      p = 1;
      if (m_st == 1 && tick && !load && !pause) begin
         for (int i = 1; i < 4; i++) begin
            p = p * 10;
            r[i-1] = ((m_val % p) == 0);
         end
      end
      return r;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: the count as a plain integer
   always @(posedge clk or negedge reset) begin
      automatic int v = m_val;
      automatic int st = m_st;
      automatic int rl = m_reload;
      automatic bit dn = 1'b0;
      automatic bit er = 1'b0;
      if (!reset) begin
         m_val <= 0;
         m_st <= 0;
         m_reload <= 0;
         m_done <= 1'b0;
         m_err <= 1'b0;
      end else begin
         if (load) begin
            if (bcd_ok(load_val)) begin
               v = bcd_int(load_val);
               st = 0;
               rl = v;
            end else begin
               er = 1'b1;
            end
         end else if (pause) begin
            if (st == 1) st = 2;
         end else if (start) begin
            if ((st == 0 && v != 0) || st == 2) st = 1;
         end else if (tick && st == 1) begin
            if (v == 1) begin
               dn = 1'b1;
`ifdef BCD_COUNTDOWN_AUTO_RELOAD_EN
               if (rl != 0) begin
                  v = rl;
               end else begin
                  v = 0;
                  st = 0;
               end
`else
               v = 0;
               st = 0;
`endif
            end else begin
               v = v - 1;
            end
         end
         m_val <= v;
         m_st <= st;
         m_reload <= rl;
         m_done <= dn;
         m_err <= er;
      end
   end

   // Per-cycle comparison against the model
   always @(negedge clk) begin
      chk("cyc_q", 32'(q), 32'(to_bcd(m_val)));
      chk("cyc_busy", 32'(busy), 32'(m_st != 0));
      chk("cyc_done", 32'(done), 32'(m_done));
      chk("cyc_load_err", 32'(load_err), 32'(m_err));
      chk("cyc_borrow", 32'(borrow), 32'(exp_borrow()));
   end

   task automatic step(input logic l, input logic [15:0] lv,
                       input logic s, input logic p, input logic t);
      load = l;
      load_val = lv;
      start = s;
      pause = p;
      tick = t;
      #1;
      bpre = borrow;
      @(posedge clk);
      @(negedge clk);
      #1;
      load = 1'b0;
      start = 1'b0;
      pause = 1'b0;
      tick = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      #2;
      chk("rst_q", 32'(q), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_done", 32'(done), 32'h0);
      chk("rst_load_err", 32'(load_err), 32'h0);
      @(negedge clk);
      #1;
      reset = 1'b1;

      step(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
      chk("start_zero_busy", 32'(busy), 32'h0);
      chk("start_zero_done", 32'(done), 32'h0);

      step(1'b1, 16'h1000, 1'b0, 1'b0, 1'b0);
      step(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
      step(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
      chk("chain_borrow", 32'(bpre), 32'h7);
      chk("chain_q", 32'(q), 32'h0999);
      step(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
      chk("chain2_borrow", 32'(bpre), 32'h0);
      chk("chain2_q", 32'(q), 32'h0998);

      step(1'b1, 16'h0003, 1'b0, 1'b0, 1'b0);
      step(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
      step(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
      step(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
      chk("term_q1", 32'(q), 32'h0001);
      chk("term_done_early", 32'(done), 32'h0);
      step(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
      chk("term_done", 32'(done), 32'h1);
`ifndef BCD_COUNTDOWN_AUTO_RELOAD_EN
      chk("term_q0", 32'(q), 32'h0);
      chk("term_busy", 32'(busy), 32'h0);
      step(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
      chk("term_done_once", 32'(done), 32'h0);
      step(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
      chk("term_hold0", 32'(q), 32'h0);
`else
      chk("term_reload_q", 32'(q), 32'h0003);
      chk("term_reload_busy", 32'(busy), 32'h1);
`endif

      step(1'b1, 16'h0010, 1'b0, 1'b0, 1'b0);
      step(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
      step(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
      step(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
      chk("pause_pre_q", 32'(q), 32'h0008);
      step(1'b0, 16'h0, 1'b0, 1'b1, 1'b1);
      chk("pause_q", 32'(q), 32'h0008);
      chk("pause_busy", 32'(busy), 32'h1);
      step(1'b0, 16'h0, 1'b1, 1'b1, 1'b0);
      step(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
      chk("paused_tick_q", 32'(q), 32'h0008);
      step(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
      step(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
      chk("resume_q", 32'(q), 32'h0007);

      step(1'b1, 16'h0012, 1'b0, 1'b0, 1'b0);
      chk("valid_load_q", 32'(q), 32'h0012);
      step(1'b1, 16'h00A5, 1'b0, 1'b0, 1'b0);
      chk("bad_load_err", 32'(load_err), 32'h1);
      chk("bad_load_q", 32'(q), 32'h0012);
      step(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
      chk("bad_load_err_once", 32'(load_err), 32'h0);

      step(1'b1, 16'h0005, 1'b0, 1'b0, 1'b0);
      step(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
      step(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
      step(1'b1, 16'h0007, 1'b0, 1'b0, 1'b1);
      chk("abort_q", 32'(q), 32'h0007);
      chk("abort_busy", 32'(busy), 32'h0);
      chk("abort_done", 32'(done), 32'h0);

      step(1'b1, 16'h0042, 1'b0, 1'b0, 1'b0);
      step(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++)
         step(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
      chk("midrun_q", 32'(q), 32'h0039);
      reset = 1'b0;
      #1;
      chk("async_rst_q", 32'(q), 32'h0);
      chk("async_rst_busy", 32'(busy), 32'h0);
      chk("async_rst_done", 32'(done), 32'h0);
      @(negedge clk);
      #1;
      reset = 1'b1;

`ifdef BCD_COUNTDOWN_AUTO_RELOAD_EN
      step(1'b1, 16'h0002, 1'b0, 1'b0, 1'b0);
      step(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
      for (int i = 1; i <= 6; i++) begin
         step(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
         chk("auto_q", 32'(q), (i % 2 == 1) ? 32'h0001 : 32'h0002);
         chk("auto_done", 32'(done), (i % 2 == 0) ? 32'h1 : 32'h0);
         chk("auto_busy", 32'(busy), 32'h1);
      end
`endif

      step(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
      step(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
